// File: rtl/dma_transfer_sequencer_if.sv
// dma_transfer_sequencer_if
// Bundles the request side and the register-file/memory/IO command side of
// the DMA transfer sequencer.
//   request : start, src_addr, dst_addr, count, dir, abort, io_ready
//   command : op, op_type, RegWrite, destination, next_source
//   memory  : mem_addr, mem_rd, mem_wr
//   io      : io_addr, io_rd, io_wr
//   status  : busy, done, aborted, remaining
// op_type carries the register-file "type" code (00 memory, 11 IO, 01 idle);
// the plain name is a reserved word in SystemVerilog.
// slave  : the sequencer side (drives commands/status).
// master : the requester side (drives the request signals).
interface dma_transfer_sequencer_if #(
  parameter int CNT_W = 8
) ();
  logic             start;
  logic [7:0]       src_addr;
  logic [7:0]       dst_addr;
  logic [CNT_W-1:0] count;
  logic             dir;
  logic             abort;
  logic             io_ready;

  logic [1:0]       op;
  logic [1:0]       op_type;
  logic             RegWrite;
  logic [7:0]       destination;
  logic [7:0]       next_source;
  logic [7:0]       mem_addr;
  logic             mem_rd;
  logic             mem_wr;
  logic [7:0]       io_addr;
  logic             io_rd;
  logic             io_wr;
  logic             busy;
  logic             done;
  logic             aborted;
  logic [CNT_W-1:0] remaining;

  modport slave (
    input  start, src_addr, dst_addr, count, dir, abort, io_ready,
    output op, op_type, RegWrite, destination, next_source,
           mem_addr, mem_rd, mem_wr, io_addr, io_rd, io_wr,
           busy, done, aborted, remaining
  );

  modport master (
    output start, src_addr, dst_addr, count, dir, abort, io_ready,
    input  op, op_type, RegWrite, destination, next_source,
           mem_addr, mem_rd, mem_wr, io_addr, io_rd, io_wr,
           busy, done, aborted, remaining
  );
endinterface

// File: rtl/dma_transfer_sequencer.sv
// dma_transfer_sequencer
// Turns one block-transfer request into a stream of lw/sw command pairs for
// the register file: each word is loaded from the source into the staging
// register (LD1/LD2), stored from it to the destination (ST1/ST2), then the
// counters advance (ADV). Memory and IO strobes/addresses accompany each
// command and IO accesses wait on io_ready.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : dma_transfer_sequencer_if.slave (request, command, status)
// Every output is a flop, loaded from the decode of the next state, so no
// input reaches an output combinationally.
module dma_transfer_sequencer #(
  parameter int unsigned STAGE_REG = 15,
  parameter int          CNT_W     = 8
) (
  input logic                      clk,
  input logic                      rst_n,
  dma_transfer_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, LD1, LD2, ST1, ST2, ADV, DONE} state_t;

  localparam logic [7:0] STAGE_IDX = {4'b0000, 4'(STAGE_REG)};

  state_t           state, state_next;
  logic             dir_q, dir_next;
  logic [7:0]       io_sel_q, io_sel_next;
  logic [7:0]       ptr_q, ptr_next;
  logic [CNT_W-1:0] rem_q, rem_next;
  logic             abort_take;

  logic [1:0]       op_next, type_next;
  logic             rw_next;
  logic [7:0]       dest_next, src_idx_next, mem_addr_next, io_addr_next;
  logic             mem_rd_next, mem_wr_next, io_rd_next, io_wr_next;
  logic             busy_next, done_next, aborted_next;

  always_comb begin
    state_next  = state;
    dir_next    = dir_q;
    io_sel_next = io_sel_q;
    ptr_next    = ptr_q;
    rem_next    = rem_q;
    abort_take  = 1'b0;

    case (state)
      IDLE: begin
        if (bus.start) begin
          // dir=0: memory source, IO destination; dir=1: the reverse.
          dir_next    = bus.dir;
          io_sel_next = bus.dir ? bus.src_addr : bus.dst_addr;
          ptr_next    = bus.dir ? bus.dst_addr : bus.src_addr;
          rem_next    = bus.count;
          state_next  = (bus.count != '0) ? LD1 : DONE;
        end
      end
      LD1:  if (!(dir_q && !bus.io_ready)) state_next = LD2;
      LD2:  state_next = ST1;
      ST1:  if (!(!dir_q && !bus.io_ready)) state_next = ST2;
      ST2:  state_next = ADV;
      ADV: begin
        rem_next   = rem_q - CNT_W'(1);
        ptr_next   = ptr_q + 8'd1;
        state_next = (rem_q == CNT_W'(1)) ? DONE : LD1;
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase

    // Abort beats everything, including completion in ADV, and freezes the
    // word count so software can see how far the transfer got.
    if (bus.abort && (state != IDLE) && (state != DONE)) begin
      state_next = IDLE;
      rem_next   = rem_q;
      ptr_next   = ptr_q;
      abort_take = 1'b1;
    end

    op_next       = 2'b00;
    type_next     = 2'b01;
    rw_next       = 1'b0;
    dest_next     = 8'd0;
    src_idx_next  = 8'd0;
    mem_addr_next = 8'd0;
    io_addr_next  = 8'd0;
    mem_rd_next   = 1'b0;
    mem_wr_next   = 1'b0;
    io_rd_next    = 1'b0;
    io_wr_next    = 1'b0;
    busy_next     = 1'b0;
    done_next     = 1'b0;
    aborted_next  = abort_take;

    case (state_next)
      LD1, LD2: begin
        op_next       = 2'b01;
        rw_next       = 1'b1;
        dest_next     = STAGE_IDX;
        type_next     = dir_next ? 2'b11 : 2'b00;
        mem_rd_next   = !dir_next;
        io_rd_next    = dir_next;
        mem_addr_next = ptr_next;
        io_addr_next  = io_sel_next;
        busy_next     = 1'b1;
      end
      ST1, ST2: begin
        op_next       = 2'b00;
        src_idx_next  = STAGE_IDX;
        type_next     = dir_next ? 2'b00 : 2'b11;
        mem_wr_next   = dir_next;
        io_wr_next    = !dir_next;
        mem_addr_next = ptr_next;
        io_addr_next  = io_sel_next;
        busy_next     = 1'b1;
      end
      ADV:     busy_next = 1'b1;
      DONE:    done_next = 1'b1;
      default: begin end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      dir_q           <= 1'b0;
      io_sel_q        <= 8'd0;
      ptr_q           <= 8'd0;
      rem_q           <= '0;
      bus.op          <= 2'b00;
      bus.op_type     <= 2'b01;
      bus.RegWrite    <= 1'b0;
      bus.destination <= 8'd0;
      bus.next_source <= 8'd0;
      bus.mem_addr    <= 8'd0;
      bus.io_addr     <= 8'd0;
      bus.mem_rd      <= 1'b0;
      bus.mem_wr      <= 1'b0;
      bus.io_rd       <= 1'b0;
      bus.io_wr       <= 1'b0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.aborted     <= 1'b0;
      bus.remaining   <= '0;
    end else begin
      state           <= state_next;
      dir_q           <= dir_next;
      io_sel_q        <= io_sel_next;
      ptr_q           <= ptr_next;
      rem_q           <= rem_next;
      bus.op          <= op_next;
      bus.op_type     <= type_next;
      bus.RegWrite    <= rw_next;
      bus.destination <= dest_next;
      bus.next_source <= src_idx_next;
      bus.mem_addr    <= mem_addr_next;
      bus.io_addr     <= io_addr_next;
      bus.mem_rd      <= mem_rd_next;
      bus.mem_wr      <= mem_wr_next;
      bus.io_rd       <= io_rd_next;
      bus.io_wr       <= io_wr_next;
      bus.busy        <= busy_next;
      bus.done        <= done_next;
      bus.aborted     <= aborted_next;
      bus.remaining   <= rem_next;
    end
  end

endmodule

// File: tb/tb_dma_transfer_sequencer.sv
// tb_dma_transfer_sequencer
// Self-checking bench for dma_transfer_sequencer: a table of transfers is
// applied in a loop; each access the bench expects is queued when the
// transfer is requested and popped when the DUT starts that access.
// Abort and mid-transfer reset are exercised by hand-written sequences.
module tb_dma_transfer_sequencer;

  typedef struct packed {
    logic [1:0] op;
    logic [1:0] typ;
    logic [3:0] strb;   // {mem_rd, mem_wr, io_rd, io_wr}
    logic       rw;
    logic [7:0] idx;
    logic [7:0] addr;
  } acc_t;

  typedef struct {
    logic       dir;
    logic [7:0] src;
    logic [7:0] dst;
    int         cnt;
    int         stall;
    int         exp_done;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;
  acc_t sb[$];
  vec_t vecs[7];

  always #5 clk = ~clk;

  dma_transfer_sequencer_if #(.CNT_W(8)) bus ();

  dma_transfer_sequencer #(.STAGE_REG(15), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_idle(input string tag);
    check_output({tag, " op"}, 32'(bus.op), 32'h0);
    check_output({tag, " type"}, 32'(bus.op_type), 32'h1);
    check_output({tag, " RegWrite"}, 32'(bus.RegWrite), 32'h0);
    check_output({tag, " indices"}, {16'h0, bus.destination, bus.next_source}, 32'h0);
    check_output({tag, " addrs"}, {16'h0, bus.mem_addr, bus.io_addr}, 32'h0);
    check_output({tag, " strobes"}, 32'({bus.mem_rd, bus.mem_wr, bus.io_rd, bus.io_wr}), 32'h0);
    check_output({tag, " status"}, 32'({bus.busy, bus.done, bus.aborted}), 32'h0);
    check_output({tag, " remaining"}, 32'(bus.remaining), 32'h0);
  endtask

  task automatic apply_stimulus(input vec_t v);
    acc_t       e, a;
    logic [3:0] prev_strb = 4'h0;
    logic [3:0] cur;
    int         done_cyc = -1;
    int         strobe_cycles = 0;
    int         stall_start = v.dir ? 1 : 3;

    sb.delete();
    for (int w = 0; w < v.cnt; w++) begin
      e.op   = 2'b01;
      e.typ  = v.dir ? 2'b11 : 2'b00;
      e.strb = v.dir ? 4'b0010 : 4'b1000;
      e.rw   = 1'b1;
      e.idx  = 8'd15;
      e.addr = v.dir ? v.src : v.src + 8'(w);
      sb.push_back(e);
      e.op   = 2'b00;
      e.typ  = v.dir ? 2'b00 : 2'b11;
      e.strb = v.dir ? 4'b0100 : 4'b0001;
      e.rw   = 1'b0;
      e.idx  = 8'd15;
      e.addr = v.dir ? v.dst + 8'(w) : v.dst;
      sb.push_back(e);
    end

    @(negedge clk);
    bus.dir      = v.dir;
    bus.src_addr = v.src;
    bus.dst_addr = v.dst;
    bus.count    = 8'(v.cnt);
    bus.start    = 1'b1;
    bus.io_ready = 1'b1;
    @(posedge clk);

    for (int c = 1; c <= 200 && done_cyc < 0; c++) begin
      @(negedge clk);
      bus.start    = 1'b0;
      bus.io_ready = !(v.stall > 0 && c >= stall_start && c < stall_start + v.stall);
      if (c == 1) check_output("remaining at first cycle", 32'(bus.remaining), 32'(v.cnt));
      cur = {bus.mem_rd, bus.mem_wr, bus.io_rd, bus.io_wr};
      if (cur != 4'h0) strobe_cycles++;
      if (cur != 4'h0 && cur != prev_strb) begin
        if (sb.size() == 0) begin
          check_output("unexpected access", 32'(cur), 32'h0);
        end else begin
          e      = sb.pop_front();
          a.op   = bus.op;
          a.typ  = bus.op_type;
          a.strb = cur;
          a.rw   = bus.RegWrite;
          a.idx  = (e.op == 2'b01) ? bus.destination : bus.next_source;
          a.addr = (e.strb[3] || e.strb[2]) ? bus.mem_addr : bus.io_addr;
          check_output("access", 32'(a), 32'(e));
        end
      end
      prev_strb = cur;
      if (bus.done) done_cyc = c;
    end

    check_output("done cycle", 32'(done_cyc), 32'(v.exp_done));
    check_output("remaining at done", 32'(bus.remaining), 32'h0);
    check_output("type at done", 32'(bus.op_type), 32'h1);
    check_output("strobe cycles", 32'(strobe_cycles), 32'(4 * v.cnt + v.stall));
    check_output("accesses left over", 32'(sb.size()), 32'h0);
    sb.delete();
  endtask

  initial begin
    int   done_seen;
    vec_t rv;

    vecs[0] = '{1'b0, 8'h0A, 8'h03, 3, 0, 16};
    vecs[1] = '{1'b1, 8'h05, 8'hFE, 3, 0, 16};
    vecs[2] = '{1'b0, 8'h14, 8'h07, 1, 4, 10};
    vecs[3] = '{1'b0, 8'h33, 8'h44, 0, 0, 1};
    vecs[4] = '{1'b1, 8'h40, 8'h30, 2, 2, 13};
    vecs[5] = '{1'b0, 8'hFF, 8'h12, 2, 0, 11};
    vecs[6] = '{1'b1, 8'h99, 8'h00, 1, 0, 6};

    bus.start    = 1'b0;
    bus.src_addr = 8'h0;
    bus.dst_addr = 8'h0;
    bus.count    = 8'h0;
    bus.dir      = 1'b0;
    bus.abort    = 1'b0;
    bus.io_ready = 1'b1;

    #2 rst_n = 1'b0;
    #1 check_idle("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) apply_stimulus(vecs[i]);

    // Abort in ST1 of word 2, with an ignored start mid-transfer.
    @(negedge clk);
    bus.dir = 1'b0; bus.src_addr = 8'h50; bus.dst_addr = 8'h09; bus.count = 8'd4;
    bus.start = 1'b1; bus.io_ready = 1'b1;
    @(posedge clk);
    done_seen = 0;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      bus.start    = (c == 3);
      bus.src_addr = (c == 3) ? 8'hAA : 8'h50;
      bus.count    = (c == 3) ? 8'd9 : 8'd4;
      bus.abort    = (c == 8) || (c == 11);
      if (bus.done) done_seen = 1;
      if (c == 4) check_output("abort: start ignored remaining", 32'(bus.remaining), 32'd4);
      if (c == 6) check_output("abort: word2 load addr", {23'h0, bus.mem_rd, bus.mem_addr}, {23'h0, 1'b1, 8'h51});
      if (c == 8) check_output("abort: in ST1", 32'({bus.io_wr, bus.io_addr}), 32'({1'b1, 8'h09}));
      if (c == 9) begin
        check_output("abort: status", 32'({bus.busy, bus.done, bus.aborted}), 32'b001);
        check_output("abort: remaining held", 32'(bus.remaining), 32'd3);
        check_output("abort: type idle", 32'(bus.op_type), 32'h1);
      end
      if (c == 10) check_output("abort: pulse one cycle", 32'(bus.aborted), 32'h0);
      if (c == 12) check_output("abort in IDLE ignored", 32'({bus.aborted, bus.busy}), 32'h0);
    end
    bus.abort = 1'b0;
    check_output("abort: no done", 32'(done_seen), 32'h0);

    // Asynchronous reset in LD2, then a normal transfer.
    @(negedge clk);
    bus.dir = 1'b0; bus.src_addr = 8'h60; bus.dst_addr = 8'h04; bus.count = 8'd2;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    check_output("reset: LD2 mem_rd", 32'(bus.mem_rd), 32'h1);
    #2 rst_n = 1'b0;
    #1 check_idle("async reset");
    @(negedge clk);
    rst_n = 1'b1;
    rv = '{1'b0, 8'h60, 8'h04, 2, 0, 11};
    apply_stimulus(rv);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
